// File: rtl/xmpl_sram_ctrl.sv
// Initiator-side controller for the xmpl_sram single-port SRAM: request channel to registered SRAM
// commands, fixed-latency read tracking, credit-guarded response FIFO. Option: XMPL_SRAM_CTRL_PARITY_EN.
module xmpl_sram_ctrl #(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned RSP_DEPTH = 2
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              sram_cs_o,
   output logic              sram_we_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic [DATA_W-1:0] sram_wdata_o,
   input  logic [DATA_W-1:0] sram_rdata_i,
`ifdef XMPL_SRAM_CTRL_PARITY_EN
   output logic              sram_wpar_o,
   input  logic              sram_rpar_i,
   output logic              rsp_err_o,
`endif
   output logic [31:0]       status_o
);

   localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned OUT_W = $clog2(RSP_DEPTH + 1);
   localparam int unsigned CNT_W = 12;

   logic              req_ready_q;
   logic              sram_cs_q;
   logic              sram_we_q;
   logic [ADDR_W-1:0] sram_addr_q;
   logic [DATA_W-1:0] sram_wdata_q;
   logic [RD_LAT:0]   pipe_q;
   logic [OUT_W-1:0]  outst_q, outst_d;
   logic [OUT_W-1:0]  fcnt_q, fcnt_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DATA_W-1:0] mem_q [RSP_DEPTH];
   logic [DATA_W-1:0] head_data_d;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic [CNT_W-1:0]  rd_cnt_q;
   logic [CNT_W-1:0]  wr_cnt_q;
   logic [3:0]        err_cnt_w;
   logic              req_acc, rd_acc, wr_acc, push, pop, head_hit;

   // Handshakes, credit accounting and FIFO pointer/head look-ahead
   always_comb begin
      req_acc     = req_valid_i & req_ready_q;
      rd_acc      = req_acc & ~req_we_i;
      wr_acc      = req_acc & req_we_i;
      push        = pipe_q[RD_LAT];
      pop         = rsp_valid_q & rsp_ready_i;
      outst_d     = outst_q + OUT_W'(rd_acc) - OUT_W'(pop);
      fcnt_d      = fcnt_q + OUT_W'(push) - OUT_W'(pop);
      rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      // Pushed word becomes the head when it lands in the slot the read pointer moves to
      head_hit    = push && (rd_ptr_d == wr_ptr_q);
      head_data_d = head_hit ? sram_rdata_i : mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         req_ready_q  <= 1'b0;
         sram_cs_q    <= 1'b0;
         sram_we_q    <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
         pipe_q       <= '0;
         outst_q      <= '0;
         fcnt_q       <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         for (int unsigned i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rd_cnt_q     <= '0;
         wr_cnt_q     <= '0;
      end else begin
         req_ready_q <= outst_d < OUT_W'(RSP_DEPTH);
         sram_cs_q   <= req_acc;
         if (req_acc) begin
            sram_we_q    <= req_we_i;
            sram_addr_q  <= req_addr_i;
            sram_wdata_q <= req_wdata_i;
         end
         pipe_q   <= {pipe_q[RD_LAT-1:0], rd_acc};
         outst_q  <= outst_d;
         fcnt_q   <= fcnt_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         if (push) mem_q[wr_ptr_q] <= sram_rdata_i;
         rsp_valid_q <= (fcnt_d != '0);
         rsp_rdata_q <= head_data_d;
         if (pop)    rd_cnt_q <= rd_cnt_q + CNT_W'(1);
         if (wr_acc) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
   end

`ifdef XMPL_SRAM_CTRL_PARITY_EN
   logic            wpar_q;
   logic            par_mem_q [RSP_DEPTH];
   logic            head_par_d;
   logic            rsp_err_q;
   logic [3:0]      err_cnt_q;

   always_comb begin
      head_par_d = head_hit ? sram_rpar_i : par_mem_q[rd_ptr_d];
   end

   // Even parity out with each command; stored read parity checked at the FIFO head
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wpar_q    <= 1'b0;
         for (int unsigned i = 0; i < RSP_DEPTH; i++) par_mem_q[i] <= 1'b0;
         rsp_err_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         if (req_acc) wpar_q <= ^req_wdata_i;
         if (push)    par_mem_q[wr_ptr_q] <= sram_rpar_i;
         rsp_err_q <= (fcnt_d != '0) && (head_par_d != (^head_data_d));
         if (pop && rsp_err_q && (err_cnt_q != 4'hF)) err_cnt_q <= err_cnt_q + 4'd1;
      end
   end

   assign sram_wpar_o = wpar_q;
   assign rsp_err_o   = rsp_err_q;
   assign err_cnt_w   = err_cnt_q;
`else
   assign err_cnt_w   = 4'd0;
`endif

   assign req_ready_o  = req_ready_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_rdata_o  = rsp_rdata_q;
   assign sram_cs_o    = sram_cs_q;
   assign sram_we_o    = sram_we_q;
   assign sram_addr_o  = sram_addr_q;
   assign sram_wdata_o = sram_wdata_q;
   assign status_o     = {err_cnt_w, 4'(outst_q), wr_cnt_q, rd_cnt_q};

endmodule
